fifo_read_ctrl: RTL and testbench

- Pointer and flag controller that drives the read-path FIFO memory (fifo_read_memory).
- Keeps the write and read pointers, the occupancy count, and the full/empty flags.
- Produces wraddr, rdaddr, fifofull and notempty for the memory, plus a read-valid strobe aligned to the memory's registered read_data.
- Sits between the sample producer (push side) and the downstream consumer (pop side).

---
 rtl/fifo_read_pkg.sv | 11 +
 rtl/fifo_ptr.sv | 21 ++
 rtl/fifo_read_ctrl.sv | 93 +++++++++
 tb/tb_fifo_read_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_pkg.sv
// Shared defaults and pointer/count types for the read-path FIFO controller.
package fifo_read_pkg;

    localparam int DEFAULT_ADDRBIT    = 5;
    localparam int DEFAULT_FIFO_DEPTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef logic [DEFAULT_ADDRBIT:0] ptr_t;
    typedef logic [DEFAULT_ADDRBIT:0] cnt_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping ADDRBIT+1-bit pointer; the extra MSB distinguishes full from empty.
module fifo_ptr #(
    parameter int ADDRBIT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ADDRBIT:0] ptr
);

    localparam logic [ADDRBIT:0] ONE = (ADDRBIT + 1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ONE;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Pointer, occupancy and flag controller for the read-path FIFO memory.
module fifo_read_ctrl
    import fifo_read_pkg::*;
#(
    parameter int ADDRBIT      = DEFAULT_ADDRBIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int AFULL_THRESH = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_en,
    input  logic               write_en,
    input  logic               read_en,
    input  logic               clr_err,
    output logic [ADDRBIT-1:0] wraddr,
    output logic [ADDRBIT-1:0] rdaddr,
    output logic               fifofull,
    output logic               notempty,
    output logic               almost_full,
    output logic [ADDRBIT:0]   count,
    output logic               rd_valid,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [ADDRBIT:0] DEPTH_C = (ADDRBIT + 1)'(FIFO_DEPTH);
    localparam logic [ADDRBIT:0] AFULL_C = (ADDRBIT + 1)'(AFULL_THRESH);
    localparam logic [ADDRBIT:0] ONE     = (ADDRBIT + 1)'(1);

    logic [ADDRBIT:0] wr_ptr;
    logic [ADDRBIT:0] rd_ptr;
    logic [ADDRBIT:0] count_next;
    logic             push_ok;
    logic             pop_ok;
    logic             ovf_set;
    logic             unf_set;

    // Handshake: a push is accepted when fifo_en & write_en and the FIFO is not
    // full; a pop when fifo_en & read_en and it is not empty. Rejected requests
    // leave pointers untouched and only raise the sticky error flags.
    assign push_ok = fifo_en & write_en & ~fifofull;
    assign pop_ok  = fifo_en & read_en & notempty;
    assign ovf_set = fifo_en & write_en & fifofull;
    assign unf_set = fifo_en & read_en & ~notempty;

    fifo_ptr #(.ADDRBIT(ADDRBIT)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ok),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.ADDRBIT(ADDRBIT)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok),
        .ptr (rd_ptr)
    );

    assign wraddr = wr_ptr[ADDRBIT-1:0];
    assign rdaddr = rd_ptr[ADDRBIT-1:0];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + ONE;
        end else if (pop_ok && !push_ok) begin
            count_next = count - ONE;
        end
    end

    // Flags come from count_next so they settle on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            fifofull    <= 1'b0;
            notempty    <= 1'b0;
            almost_full <= 1'b0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= count_next;
            fifofull    <= (count_next == DEPTH_C);
            notempty    <= (count_next != '0);
            almost_full <= (count_next >= AFULL_C);
            rd_valid    <= pop_ok;
            overflow    <= ovf_set | (overflow & ~clr_err);
            underflow   <= unf_set | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: fill, overflow, full push+pop, drain, wrap, disable, async reset.
module tb_fifo_read_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_en = 1'b0;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [4:0] wraddr;
    logic [4:0] rdaddr;
    logic       fifofull;
    logic       notempty;
    logic       almost_full;
    logic [5:0] count;
    logic       rd_valid;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;
    int wr_model = 0;
    int rd_model = 0;
    logic [4:0] exp_q[$];

    fifo_read_ctrl #(.ADDRBIT(5), .FIFO_DEPTH(32), .AFULL_THRESH(28)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_en     (fifo_en),
        .write_en    (write_en),
        .read_en     (read_en),
        .clr_err     (clr_err),
        .wraddr      (wraddr),
        .rdaddr      (rdaddr),
        .fifofull    (fifofull),
        .notempty    (notempty),
        .almost_full (almost_full),
        .count       (count),
        .rd_valid    (rd_valid),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, then settle 1 time unit past the edge.
    task automatic cyc(input logic fe, input logic we, input logic re, input logic clr);
        fifo_en  = fe;
        write_en = we;
        read_en  = re;
        clr_err  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_wraddr"}, 32'(wraddr), 0);
        check({tag, "_rdaddr"}, 32'(rdaddr), 0);
        check({tag, "_full"}, 32'(fifofull), 0);
        check({tag, "_notempty"}, 32'(notempty), 0);
        check({tag, "_afull"}, 32'(almost_full), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_underflow"}, 32'(underflow), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Fill 32 entries
        for (int i = 0; i < 32; i++) begin
            check("fill_wraddr", 32'(wraddr), 32'(wr_model % 32));
            exp_q.push_back(5'(wr_model % 32));
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            wr_model++;
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_afull", 32'(almost_full), 32'(i + 1 >= 28));
            check("fill_full", 32'(fifofull), 32'(i + 1 == 32));
            check("fill_notempty", 32'(notempty), 1);
        end

        // Push while full
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_wraddr", 32'(wraddr), 0);
        check("ovf_count", 32'(count), 32);
        check("ovf_full", 32'(fifofull), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 0);

        // Push+pop while full: pop wins, push flagged
        check("fullpp_rdaddr_pre", 32'(rdaddr), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        rd_model++;
        check("fullpp_count", 32'(count), 31);
        check("fullpp_full", 32'(fifofull), 0);
        check("fullpp_rdaddr", 32'(rdaddr), 1);
        check("fullpp_overflow", 32'(overflow), 1);
        check("fullpp_rd_valid", 32'(rd_valid), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("fullpp_clr", 32'(overflow), 0);
        check("idle_rd_valid", 32'(rd_valid), 0);

        // Drain remaining 31
        for (int i = 0; i < 31; i++) begin
            check("drain_rdaddr", 32'(rdaddr), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            rd_model++;
            check("drain_count", 32'(count), 32'(30 - i));
            check("drain_rd_valid", 32'(rd_valid), 1);
        end
        check("drained_notempty", 32'(notempty), 0);
        check("drained_rdaddr", 32'(rdaddr), 32'(rd_model % 32));

        // Pop while empty
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("unf_flag", 32'(underflow), 1);
        check("unf_notempty", 32'(notempty), 0);
        check("unf_count", 32'(count), 0);
        check("unf_rd_valid", 32'(rd_valid), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("unf_clr", 32'(underflow), 0);

        // Wrap-around at steady occupancy of 3
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5'(wr_model % 32));
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            wr_model++;
        end
        check("wrap_pre_count", 32'(count), 3);
        for (int i = 0; i < 50; i++) begin
            check("wrap_wraddr", 32'(wraddr), 32'(wr_model % 32));
            check("wrap_rdaddr", 32'(rdaddr), 32'(exp_q[0]));
            exp_q.push_back(5'(wr_model % 32));
            void'(exp_q.pop_front());
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            wr_model++;
            rd_model++;
            check("wrap_count", 32'(count), 3);
            check("wrap_errs", 32'({overflow, underflow}), 0);
            check("wrap_rd_valid", 32'(rd_valid), 1);
        end
        check("wrap_final_wraddr", 32'(wraddr), 21);
        check("wrap_final_rdaddr", 32'(rdaddr), 18);

        // Disabled: requests ignored
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            check("dis_wraddr", 32'(wraddr), 32'(wr_model % 32));
            check("dis_rdaddr", 32'(rdaddr), 32'(rd_model % 32));
            check("dis_count", 32'(count), 3);
            check("dis_rd_valid", 32'(rd_valid), 0);
            check("dis_errs", 32'({overflow, underflow}), 0);
        end

        // Build to 10 entries, then async reset during a push burst
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("burst_count", 32'(count), 10);
        fifo_en  = 1'b1;
        write_en = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        fifo_en  = 1'b0;
        write_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_wraddr", 32'(wraddr), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_count", 32'(count), 1);
        check("post_rst_wraddr_next", 32'(wraddr), 1);
        check("post_rst_notempty", 32'(notempty), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
